ast_to_strings: RTL and testbench
=================================

// Module: ast_to_strings
// PURPOSE
//  Avalon-ST sink deserializer; the receive-side counterpart of the string-to-AST path.
//  Collects one packet (one string) per transfer into a MAX_STR_SIZE-byte parallel word.
//  Emits the word with its byte length on a valid/ready port.
//  Sits in front of the bloom-filter string-load and lookup logic.
// PARAMETERS
//  BYTE_W            8    bits per symbol
//  MIN_STR_SIZE      6    shortest accepted string, bytes
//  MAX_STR_SIZE      20   longest accepted string, bytes
//  AST_SINK_SYMBOLS  1    symbols per AST beat
//  AST_SINK_ORDER    1    1: ast_sink_data_i[SYMBOLS-1] is the earliest symbol; 0: [0] is earliest
//  AST_SINK_EMPTY_W  SYMBOLS==1 ? 1 : $clog2(SYMBOLS)
//  LEN_W             $clog2(MAX_STR_SIZE+1)  (derived, localparam)
// PORTS
//  clk_i                     in   1                       single clock
//  srst_i                    in   1                       sync reset, active high
//  ast_sink_data_i           in   SYMBOLS*BYTE_W          beat data
//  ast_sink_valid_i          in   1                       beat valid
//  ast_sink_ready_o          out  1                       beat accepted when valid&&ready
//  ast_sink_empty_i          in   AST_SINK_EMPTY_W        unused trailing symbols; only on EOP beat
//  ast_sink_startofpacket_i  in   1                       first beat of string
//  ast_sink_endofpacket_i    in   1                       last beat of string
//  str_data_o                out  MAX_STR_SIZE*BYTE_W     [i] = i-th received byte; bytes >= len are 0
//  str_len_o                 out  LEN_W                   string length, bytes
//  str_valid_o               out  1                       string available
//  str_ready_i               in   1                       string taken when valid&&ready
//  err_short_o               out  1                       1-cycle pulse: string < MIN dropped
//  err_long_o                out  1                       1-cycle pulse: string > MAX dropped
//  err_framing_o             out  1                       1-cycle pulse: beat without SOP in IDLE, or SOP inside a packet
// BEHAVIOUR
//  Reset: state IDLE; cnt=0; str_data_o=0; str_len_o=0; str_valid_o=0; all err_*=0; ast_sink_ready_o=1.
//  Beat bytes n = SYMBOLS - (eop ? empty : 0). Bytes are written at str_data_o[cnt .. cnt+n-1] in arrival order.
//  States:
//   IDLE:    accepted beat with SOP -> clear buffer, write, cnt=n; EOP ? check : COLLECT.
//            Accepted beat without SOP -> discard, err_framing pulse, stay in IDLE.
//   COLLECT: accepted beat; SOP -> err_framing, restart as in IDLE.
//            cnt+n > MAX -> no write; EOP ? (err_long, IDLE) : DROP.
//            Otherwise write, cnt+=n; EOP -> check.
//   DROP:    discard beats; on EOP -> err_long, IDLE. SOP in DROP -> err_framing, restart.
//   check:   final len < MIN -> err_short, IDLE; else str_len_o=len, str_valid_o=1, OUTPUT.
//   OUTPUT:  ast_sink_ready_o=0; hold str_* stable until str_ready_i; then str_valid_o=0, IDLE.
//  ast_sink_ready_o = (state != OUTPUT); registered-equivalent, no dependency on str_ready_i.
//  Latency: str_valid_o rises the cycle after the EOP beat is accepted.
//   Throughput is 1 bubble beat per string (the OUTPUT cycle).
//  err_* are registered and asserted exactly 1 cycle after the offending beat is accepted;
//   at most one err_* bit is set per cycle.
//  Exactly-MAX strings are valid; the MIN boundary is inclusive.
//  empty on a non-EOP beat is ignored.
//  Reset mid-packet or mid-OUTPUT: partial or pending string is discarded, no error pulse.
// STRUCTURE
//  strings_pkg: LEN_W calc function, state_t enum {IDLE,COLLECT,DROP,OUTPUT}.
//  Sub-module ast_beat_unpack: reorders beat symbols per AST_SINK_ORDER and computes n (combinational).
//  Top holds the FSM, byte counter and shift/write buffer.
// TESTING
//  1. SYMBOLS=1, 6-byte string "ABCDEF" -> str_len=6, str_data[0]='A', [5]='F', [6..19]=0; valid 1 cycle after EOP.
//  2. SYMBOLS=4, 10-byte string over 3 beats, empty=2 on EOP -> len=10, bytes in order; ORDER=0 and ORDER=1 both pass.
//  3. 5-byte packet -> err_short pulse, no str_valid; 25-byte packet -> err_long at EOP, ready high throughout.
//  4. Beat without SOP in IDLE -> err_framing, discarded; SOP mid-packet -> err_framing, new string output alone.
//  5. Hold str_ready_i=0 for 10 cycles -> ast_sink_ready_o=0 and str_* stable; release -> next string accepted.
//  6. srst_i asserted mid-COLLECT and in OUTPUT -> all outputs at reset values next cycle; following packet correct.

Source files
------------

// File: rtl/strings_pkg.sv
// Shared types and helpers for the AST-to-string receive path.
package strings_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Width needed to hold a byte count from 0 up to max_size inclusive.
    function automatic int calc_len_w(input int max_size);
        return $clog2(max_size + 1);
    endfunction

endpackage

// File: rtl/ast_beat_unpack.sv
// Puts the symbols of one AST beat into arrival order and reports how many
// of them carry string bytes (trailing empty symbols only count on EOP).
module ast_beat_unpack #(
    parameter int BYTE_W  = 8,
    parameter int SYMBOLS = 1,
    parameter int ORDER   = 1,
    parameter int EMPTY_W = 1,
    localparam int N_W    = $clog2(SYMBOLS + 1)
) (
    input  logic [SYMBOLS*BYTE_W-1:0] data_i,
    input  logic [EMPTY_W-1:0]        empty_i,
    input  logic                      eop_i,
    output logic [SYMBOLS*BYTE_W-1:0] sym_o,
    output logic [N_W-1:0]            n_o
);

    // sym_o slot gi holds the gi-th earliest symbol of the beat.
    genvar gi;
    generate
        for (gi = 0; gi < SYMBOLS; gi++) begin : g_sym
            localparam int SRC = (ORDER != 0) ? (SYMBOLS - 1 - gi) : gi;
            assign sym_o[gi*BYTE_W +: BYTE_W] = data_i[SRC*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Byte count of the beat; an out-of-range empty value yields zero bytes.
    always_comb begin
        if (!eop_i) begin
            n_o = N_W'(SYMBOLS);
        end else if (int'(empty_i) >= SYMBOLS) begin
            n_o = '0;
        end else begin
            n_o = N_W'(SYMBOLS - int'(empty_i));
        end
    end

endmodule

// File: rtl/ast_to_strings.sv
// Avalon-ST sink that gathers one packet into a parallel string word and
// hands it out with its length on a valid/ready port.
module ast_to_strings
    import strings_pkg::*;
#(
    parameter int BYTE_W           = 8,
    parameter int MIN_STR_SIZE     = 6,
    parameter int MAX_STR_SIZE     = 20,
    parameter int AST_SINK_SYMBOLS = 1,
    parameter int AST_SINK_ORDER   = 1,
    parameter int AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
    localparam int LEN_W           = calc_len_w(MAX_STR_SIZE)
) (
    input  logic                               clk_i,
    input  logic                               srst_i,
    input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0] ast_sink_data_i,
    input  logic                               ast_sink_valid_i,
    output logic                               ast_sink_ready_o,
    input  logic [AST_SINK_EMPTY_W-1:0]        ast_sink_empty_i,
    input  logic                               ast_sink_startofpacket_i,
    input  logic                               ast_sink_endofpacket_i,
    output logic [MAX_STR_SIZE*BYTE_W-1:0]     str_data_o,
    output logic [LEN_W-1:0]                   str_len_o,
    output logic                               str_valid_o,
    input  logic                               str_ready_i,
    output logic                               err_short_o,
    output logic                               err_long_o,
    output logic                               err_framing_o
);

    localparam int N_W   = $clog2(AST_SINK_SYMBOLS + 1);
    localparam int SUM_W = LEN_W + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_STR_SIZE);
    localparam logic [SUM_W-1:0] MIN_SUM = SUM_W'(MIN_STR_SIZE);

    state_t                                 state_q, state_d;
    logic [LEN_W-1:0]                       cnt_q, cnt_d;
    logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]    buf_q, buf_d;
    logic [LEN_W-1:0]                       len_q, len_d;
    logic                                   valid_q, valid_d;
    logic                                   err_short_q, err_short_d;
    logic                                   err_long_q, err_long_d;
    logic                                   err_framing_q, err_framing_d;

    logic [AST_SINK_SYMBOLS*BYTE_W-1:0]     sym;
    logic [N_W-1:0]                         n_beat;
    logic                                   accept;
    logic                                   sop;
    logic                                   eop;
    logic [LEN_W-1:0]                       wr_base;
    logic [SUM_W-1:0]                       sum;
    logic                                   wr_en;
    logic                                   clr_en;
    logic                                   do_start;
    logic                                   do_finish;

    ast_beat_unpack #(
        .BYTE_W  (BYTE_W),
        .SYMBOLS (AST_SINK_SYMBOLS),
        .ORDER   (AST_SINK_ORDER),
        .EMPTY_W (AST_SINK_EMPTY_W)
    ) u_unpack (
        .data_i  (ast_sink_data_i),
        .empty_i (ast_sink_empty_i),
        .eop_i   (ast_sink_endofpacket_i),
        .sym_o   (sym),
        .n_o     (n_beat)
    );

    assign sop    = ast_sink_startofpacket_i;
    assign eop    = ast_sink_endofpacket_i;
    assign accept = ast_sink_valid_i && (state_q != OUTPUT);

    // A SOP beat always restarts at byte 0; only a continuation appends at cnt.
    assign wr_base = (state_q == COLLECT && !sop) ? cnt_q : '0;
    assign sum     = {1'b0, wr_base} + SUM_W'(n_beat);

    // Next-state, counter, length and error-pulse decisions for the accepted beat.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        valid_d       = valid_q;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        err_framing_d = 1'b0;
        wr_en         = 1'b0;
        clr_en        = 1'b0;
        do_start      = 1'b0;
        do_finish     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sop) begin
                        do_start = 1'b1;
                    end else begin
                        err_framing_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (sop) begin
                        err_framing_d = 1'b1;
                        do_start      = 1'b1;
                    end else if (sum > MAX_SUM) begin
                        if (eop) begin
                            err_long_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        wr_en     = 1'b1;
                        cnt_d     = sum[LEN_W-1:0];
                        do_finish = eop;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (sop) begin
                        err_framing_d = 1'b1;
                        do_start      = 1'b1;
                    end else if (eop) begin
                        err_long_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (str_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_start) begin
            clr_en    = 1'b1;
            wr_en     = 1'b1;
            cnt_d     = sum[LEN_W-1:0];
            state_d   = COLLECT;
            do_finish = eop;
        end

        // A framing pulse on the same beat takes precedence over err_short.
        if (do_finish) begin
            if (sum < MIN_SUM) begin
                err_short_d = !err_framing_d;
                state_d     = IDLE;
            end else begin
                len_d   = sum[LEN_W-1:0];
                valid_d = 1'b1;
                state_d = OUTPUT;
            end
        end
    end

    // Per-byte buffer update: write beat symbols that land here, clear on a new string.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_STR_SIZE; gi++) begin : g_byte
            logic              hit;
            logic [BYTE_W-1:0] val;
            always_comb begin
                hit = 1'b0;
                val = '0;
                for (int k = 0; k < AST_SINK_SYMBOLS; k++) begin
                    if ((k < int'(n_beat)) && (int'(wr_base) + k == gi)) begin
                        hit = 1'b1;
                        val = sym[k*BYTE_W +: BYTE_W];
                    end
                end
            end
            assign buf_d[gi] = (wr_en && hit) ? val : (clr_en ? '0 : buf_q[gi]);
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            buf_q         <= '0;
            len_q         <= '0;
            valid_q       <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_framing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            len_q         <= len_d;
            valid_q       <= valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_framing_q <= err_framing_d;
        end
    end

    assign ast_sink_ready_o = (state_q != OUTPUT);
    assign str_data_o       = buf_q;
    assign str_len_o        = len_q;
    assign str_valid_o      = valid_q;
    assign err_short_o      = err_short_q;
    assign err_long_o       = err_long_q;
    assign err_framing_o    = err_framing_q;

endmodule

// File: tb/tb_ast_to_strings.sv
// Bench for ast_to_strings: a 1-symbol instance plus two 4-symbol instances
// (both symbol orders) fed the same logical beats.
module tb_ast_to_strings;

    localparam int BW   = 8;
    localparam int MINS = 6;
    localparam int MAXS = 20;
    localparam int LW   = 5;
    localparam int DW   = MAXS * BW;

    typedef enum int {K_OK = 0, K_SHORT = 1, K_LONG = 2} kind_t;
    typedef struct {
        int    len;
        kind_t kind;
        int    hold;
    } vec_t;

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] pkt_q[$];

    // 1-symbol instance signals
    logic [7:0]    a_data;
    logic          a_valid, a_sop, a_eop, a_sr;
    logic [0:0]    a_empty;
    logic          a_ready, a_sv, a_es, a_el, a_ef;
    logic [DW-1:0] a_sdata;
    logic [LW-1:0] a_len;

    // 4-symbol instances signals
    logic [7:0]    b_sym [4];
    logic [31:0]   b_data1, b_data0;
    logic          b_valid, b_sop, b_eop, b_sr;
    logic [1:0]    b_empty;
    logic          b1_ready, b1_sv, b1_es, b1_el, b1_ef;
    logic [DW-1:0] b1_sdata;
    logic [LW-1:0] b1_len;
    logic          b0_ready, b0_sv, b0_es, b0_el, b0_ef;
    logic [DW-1:0] b0_sdata;
    logic [LW-1:0] b0_len;

    // ORDER=1: data[3] is earliest; ORDER=0: data[0] is earliest.
    assign b_data1 = {b_sym[0], b_sym[1], b_sym[2], b_sym[3]};
    assign b_data0 = {b_sym[3], b_sym[2], b_sym[1], b_sym[0]};

    ast_to_strings #(.BYTE_W(BW), .MIN_STR_SIZE(MINS), .MAX_STR_SIZE(MAXS),
                     .AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1), .AST_SINK_EMPTY_W(1)) dut_a (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(a_data), .ast_sink_valid_i(a_valid), .ast_sink_ready_o(a_ready),
        .ast_sink_empty_i(a_empty), .ast_sink_startofpacket_i(a_sop), .ast_sink_endofpacket_i(a_eop),
        .str_data_o(a_sdata), .str_len_o(a_len), .str_valid_o(a_sv), .str_ready_i(a_sr),
        .err_short_o(a_es), .err_long_o(a_el), .err_framing_o(a_ef));

    ast_to_strings #(.BYTE_W(BW), .MIN_STR_SIZE(MINS), .MAX_STR_SIZE(MAXS),
                     .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1), .AST_SINK_EMPTY_W(2)) dut_b1 (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(b_data1), .ast_sink_valid_i(b_valid), .ast_sink_ready_o(b1_ready),
        .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop), .ast_sink_endofpacket_i(b_eop),
        .str_data_o(b1_sdata), .str_len_o(b1_len), .str_valid_o(b1_sv), .str_ready_i(b_sr),
        .err_short_o(b1_es), .err_long_o(b1_el), .err_framing_o(b1_ef));

    ast_to_strings #(.BYTE_W(BW), .MIN_STR_SIZE(MINS), .MAX_STR_SIZE(MAXS),
                     .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(0), .AST_SINK_EMPTY_W(2)) dut_b0 (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(b_data0), .ast_sink_valid_i(b_valid), .ast_sink_ready_o(b0_ready),
        .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop), .ast_sink_endofpacket_i(b_eop),
        .str_data_o(b0_sdata), .str_len_o(b0_len), .str_valid_o(b0_sv), .str_ready_i(b_sr),
        .err_short_o(b0_es), .err_long_o(b0_el), .err_framing_o(b0_ef));

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the outcome of a string depends only on its total length.
    function automatic kind_t model_kind(input int len);
        if (len < MINS) return K_SHORT;
        if (len > MAXS) return K_LONG;
        return K_OK;
    endfunction

    // Reference: received bytes in order, everything past the length is zero.
    function automatic logic [DW-1:0] model_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < pkt_q.size() && i < MAXS; i++) d[i*BW +: BW] = pkt_q[i];
        return d;
    endfunction

    task automatic fill(input int len, input bit rnd, input int base);
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic sv, input logic es,
                           input logic el, input logic ef, input logic [LW-1:0] len,
                           input logic [DW-1:0] data, input kind_t k, input logic [DW-1:0] exp_data);
        check({tag, " str_valid"}, DW'(sv), DW'(k == K_OK));
        check({tag, " err_short"}, DW'(es), DW'(k == K_SHORT));
        check({tag, " err_long"}, DW'(el), DW'(k == K_LONG));
        check({tag, " err_framing"}, DW'(ef), '0);
        check({tag, " sink_ready"}, DW'(rdy), DW'(k != K_OK));
        if (k == K_OK) begin
            check({tag, " str_len"}, DW'(len), DW'(pkt_q.size()));
            check({tag, " str_data"}, data, exp_data);
        end
    endtask

    task automatic chk_reset_a();
        check("a rst ready", DW'(a_ready), DW'(1));
        check("a rst valid", DW'(a_sv), '0);
        check("a rst len", DW'(a_len), '0);
        check("a rst data", a_sdata, '0);
        check("a rst errs", DW'({a_es, a_el, a_ef}), '0);
    endtask

    // Sends pkt_q on the 1-symbol instance. hold<0 leaves the string pending.
    task automatic send_a(input bit do_eop, input bit frame_first, input kind_t k,
                          input int hold, input bit gaps);
        int n = pkt_q.size();
        logic [DW-1:0] exp = model_data();
        for (int i = 0; i < n; i++) begin
            check("a ready in packet", DW'(a_ready), DW'(1));
            a_valid = 1'b1;
            a_data  = pkt_q[i];
            a_sop   = (i == 0);
            a_eop   = do_eop && (i == n - 1);
            a_empty = 1'($urandom);
            if (a_eop) a_empty = 1'b0;
            @(posedge clk); #1;
            a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
            if (!(do_eop && i == n - 1)) begin
                check("a framing mid", DW'(a_ef), DW'(frame_first && i == 0));
                check("a quiet mid", DW'({a_sv, a_es, a_el}), '0);
                if (gaps && $urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                    check("a quiet gap", DW'({a_sv, a_es, a_el, a_ef}), '0);
                end
            end
        end
        if (do_eop) begin
            chk_out("a eop", a_ready, a_sv, a_es, a_el, a_ef, a_len, a_sdata, k, exp);
            $display("A packet len=%0d kind=%0d hold=%0d", n, k, hold);
            if (k == K_OK && hold >= 0) begin
                for (int c = 0; c < hold; c++) begin
                    @(posedge clk); #1;
                    chk_out("a hold", a_ready, a_sv, a_es, a_el, a_ef, a_len, a_sdata, K_OK, exp);
                end
                a_sr = 1'b1;
                @(posedge clk); #1;
                a_sr = 1'b0;
                check("a valid after take", DW'(a_sv), '0);
                check("a ready after take", DW'(a_ready), DW'(1));
            end
        end else begin
            $display("A partial packet len=%0d", n);
        end
    endtask

    // Sends pkt_q on both 4-symbol instances; padding symbols are random junk.
    task automatic send_b(input kind_t k, input int hold);
        int n = pkt_q.size();
        int nb = (n + 3) / 4;
        logic [DW-1:0] exp = model_data();
        for (int bi = 0; bi < nb; bi++) begin
            check("b1 ready in packet", DW'(b1_ready), DW'(1));
            check("b0 ready in packet", DW'(b0_ready), DW'(1));
            for (int s = 0; s < 4; s++)
                b_sym[s] = (bi * 4 + s < n) ? pkt_q[bi * 4 + s] : 8'($urandom);
            b_valid = 1'b1;
            b_sop   = (bi == 0);
            b_eop   = (bi == nb - 1);
            b_empty = b_eop ? 2'(nb * 4 - n) : 2'($urandom);
            @(posedge clk); #1;
            b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
            if (bi != nb - 1) begin
                check("b1 quiet mid", DW'({b1_sv, b1_es, b1_el, b1_ef}), '0);
                check("b0 quiet mid", DW'({b0_sv, b0_es, b0_el, b0_ef}), '0);
            end
        end
        chk_out("b1 eop", b1_ready, b1_sv, b1_es, b1_el, b1_ef, b1_len, b1_sdata, k, exp);
        chk_out("b0 eop", b0_ready, b0_sv, b0_es, b0_el, b0_ef, b0_len, b0_sdata, k, exp);
        $display("B packet len=%0d beats=%0d kind=%0d hold=%0d", n, nb, k, hold);
        if (k == K_OK) begin
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                chk_out("b1 hold", b1_ready, b1_sv, b1_es, b1_el, b1_ef, b1_len, b1_sdata, K_OK, exp);
                chk_out("b0 hold", b0_ready, b0_sv, b0_es, b0_el, b0_ef, b0_len, b0_sdata, K_OK, exp);
            end
            b_sr = 1'b1;
            @(posedge clk); #1;
            b_sr = 1'b0;
            check("b1 valid after take", DW'(b1_sv), '0);
            check("b0 valid after take", DW'(b0_sv), '0);
        end
    endtask

    initial begin
        vec_t ta [8];
        vec_t tb [7];
        int   len;

        a_data = '0; a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_sr = 1'b0; a_empty = '0;
        for (int s = 0; s < 4; s++) b_sym[s] = '0;
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_sr = 1'b0; b_empty = '0;

        ta = '{'{6, K_OK, 0}, '{5, K_SHORT, 0}, '{20, K_OK, 3}, '{21, K_LONG, 0},
               '{25, K_LONG, 0}, '{1, K_SHORT, 0}, '{13, K_OK, 10}, '{7, K_OK, 0}};
        tb = '{'{10, K_OK, 0}, '{20, K_OK, 1}, '{21, K_LONG, 0}, '{5, K_SHORT, 0},
               '{6, K_OK, 0}, '{24, K_LONG, 0}, '{17, K_OK, 2}};

        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        chk_reset_a();
        check("b1 rst state", DW'({b1_ready, b1_sv, b1_es, b1_el, b1_ef}), DW'(5'b10000));
        check("b0 rst state", DW'({b0_ready, b0_sv, b0_es, b0_el, b0_ef}), DW'(5'b10000));
        check("b1 rst data", b1_sdata, '0);

        // Table: 1-symbol instance, letters 'A'.. as payload.
        for (int t = 0; t < 8; t++) begin
            fill(ta[t].len, 1'b0, 65);
            send_a(1'b1, 1'b0, ta[t].kind, ta[t].hold, 1'b0);
        end

        // Table: 4-symbol instances, both symbol orders.
        for (int t = 0; t < 7; t++) begin
            fill(tb[t].len, 1'b0, 97);
            send_b(tb[t].kind, tb[t].hold);
        end

        // Beat without SOP while idle is dropped with a framing pulse.
        a_valid = 1'b1; a_sop = 1'b0; a_eop = 1'b1; a_data = 8'h5A;
        @(posedge clk); #1;
        a_valid = 1'b0; a_eop = 1'b0;
        check("a orphan framing", DW'(a_ef), DW'(1));
        check("a orphan no string", DW'({a_sv, a_es, a_el}), '0);
        @(posedge clk); #1;
        check("a framing pulse width", DW'(a_ef), '0);

        // SOP inside a packet restarts; only the new string is delivered.
        fill(3, 1'b0, 48);
        send_a(1'b0, 1'b0, K_OK, 0, 1'b0);
        fill(7, 1'b0, 97);
        send_a(1'b1, 1'b1, K_OK, 0, 1'b0);

        // SOP while dropping an oversized packet restarts too.
        fill(22, 1'b0, 48);
        send_a(1'b0, 1'b0, K_OK, 0, 1'b0);
        fill(8, 1'b0, 112);
        send_a(1'b1, 1'b1, K_OK, 1, 1'b0);

        // Reset in the middle of collecting.
        fill(4, 1'b1, 0);
        send_a(1'b0, 1'b0, K_OK, 0, 1'b0);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        chk_reset_a();
        fill(9, 1'b1, 0);
        send_a(1'b1, 1'b0, K_OK, 0, 1'b0);

        // Reset while a string is waiting to be taken.
        fill(8, 1'b1, 0);
        send_a(1'b1, 1'b0, K_OK, -1, 1'b0);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        chk_reset_a();
        fill(6, 1'b1, 0);
        send_a(1'b1, 1'b0, K_OK, 0, 1'b0);

        // Randomised packets against the length-based reference.
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 26);
            fill(len, 1'b1, 0);
            send_a(1'b1, 1'b0, model_kind(len), $urandom_range(0, 3), 1'b1);
            len = $urandom_range(1, 30);
            fill(len, 1'b1, 0);
            send_b(model_kind(len), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
